// File: rtl/mig_ui_responder.sv
// Block-RAM stand-in for the MIG 7-series user interface: queues app commands and
// write data, services them in order, and returns read data after a fixed latency.
module mig_ui_responder #(
  parameter int unsigned ADDR_W       = 28,
  parameter int unsigned DATA_W       = 128,
  parameter int unsigned MEM_AW       = 10,
  parameter int unsigned RD_LATENCY   = 4,
  parameter int unsigned CALIB_CYCLES = 64,
  parameter int unsigned BACKPRESSURE = 0
) (
  input  logic                ui_clk,
  input  logic                ui_clk_sync_rst,
  input  logic [ADDR_W-1:0]   app_addr,
  input  logic [2:0]          app_cmd,
  input  logic                app_en,
  output logic                app_rdy,
  input  logic [DATA_W-1:0]   app_wdf_data,
  input  logic [DATA_W/8-1:0] app_wdf_mask,
  input  logic                app_wdf_wren,
  input  logic                app_wdf_end,
  output logic                app_wdf_rdy,
  output logic [DATA_W-1:0]   app_rd_data,
  output logic                app_rd_data_valid,
  output logic                app_rd_data_end,
  output logic                init_calib_complete,
  output logic                proto_err
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned DEPTH  = 1 << MEM_AW;
  localparam int unsigned CAL_W  = $clog2(CALIB_CYCLES + 2);
  localparam bit          BP_EN  = (BACKPRESSURE != 0);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [2:0]  CMD_WR = 3'b000;
  localparam logic [2:0]  CMD_RD = 3'b001;
  localparam logic [2:0]  FIFO_FULL = 3'd4;

  typedef enum logic [1:0] {S_CALIB, S_IDLE, S_RD, S_WR} state_t;

  typedef struct packed {
    logic [2:0]        cmd;
    logic [MEM_AW-1:0] idx;
  } cmd_entry_t;

  state_t            state, state_nxt;
  logic [CAL_W-1:0]  cal_cnt;
  logic              calib_nxt;
  logic [15:0]       lfsr, lfsr_nxt;

  cmd_entry_t        cmd_q [4];
  logic [1:0]        cmd_wp, cmd_rp;
  logic [2:0]        cmd_cnt, cmd_cnt_nxt;
  cmd_entry_t        cmd_head;

  logic [DATA_W-1:0] wdf_data_q [4];
  logic [MASK_W-1:0] wdf_mask_q [4];
  logic [1:0]        wdf_wp, wdf_rp;
  logic [2:0]        wdf_cnt, wdf_cnt_nxt;

  logic              cmd_push, cmd_pop, wdf_push, wdf_pop;
  logic              rd_issue, wr_commit, bad_cmd;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [RD_LATENCY-1:0] vld_pipe;
  logic [DATA_W-1:0]     dat_pipe [RD_LATENCY];

  // Only the line-index bits address storage; the rest wrap or are sub-line offsets.
  logic unused_addr;
  assign unused_addr = ^{app_addr[2:0], app_addr[ADDR_W-1:3+MEM_AW]};

  assign cmd_push    = app_en && app_rdy;
  assign wdf_push    = app_wdf_wren && app_wdf_rdy;
  assign cmd_head    = cmd_q[cmd_rp];
  assign cmd_cnt_nxt = cmd_cnt + {2'b00, cmd_push} - {2'b00, cmd_pop};
  assign wdf_cnt_nxt = wdf_cnt + {2'b00, wdf_push} - {2'b00, wdf_pop};
  assign calib_nxt   = init_calib_complete || (cal_cnt == CAL_W'(CALIB_CYCLES - 1));
  assign lfsr_nxt    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  // Calibration timer, LFSR, ready flags (pre-computed from next-state so they are flops).
  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      cal_cnt             <= '0;
      init_calib_complete <= 1'b0;
      lfsr                <= LFSR_SEED;
      app_rdy             <= 1'b0;
      app_wdf_rdy         <= 1'b0;
      proto_err           <= 1'b0;
    end else begin
      if (!init_calib_complete) cal_cnt <= cal_cnt + CAL_W'(1);
      init_calib_complete <= calib_nxt;
      lfsr                <= lfsr_nxt;
      app_rdy     <= calib_nxt && (cmd_cnt_nxt != FIFO_FULL) && !(BP_EN && lfsr_nxt[0]);
      app_wdf_rdy <= calib_nxt && (wdf_cnt_nxt != FIFO_FULL) && !(BP_EN && lfsr_nxt[1]);
      if ((app_wdf_wren != app_wdf_end) || (app_en && !init_calib_complete) || bad_cmd)
        proto_err <= 1'b1;
    end
  end

  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      cmd_wp  <= '0;
      cmd_rp  <= '0;
      cmd_cnt <= '0;
      wdf_wp  <= '0;
      wdf_rp  <= '0;
      wdf_cnt <= '0;
    end else begin
      if (cmd_push) cmd_wp <= cmd_wp + 2'd1;
      if (cmd_pop)  cmd_rp <= cmd_rp + 2'd1;
      if (wdf_push) wdf_wp <= wdf_wp + 2'd1;
      if (wdf_pop)  wdf_rp <= wdf_rp + 2'd1;
      cmd_cnt <= cmd_cnt_nxt;
      wdf_cnt <= wdf_cnt_nxt;
    end
  end

  always_ff @(posedge ui_clk) begin
    if (cmd_push) cmd_q[cmd_wp] <= cmd_entry_t'{cmd: app_cmd, idx: app_addr[3+MEM_AW-1:3]};
    if (wdf_push) begin
      wdf_data_q[wdf_wp] <= app_wdf_data;
      wdf_mask_q[wdf_wp] <= app_wdf_mask;
    end
  end

  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) state <= S_CALIB;
    else                 state <= state_nxt;
  end

  // Service FSM: strictly in-order, a write at the head stalls everything behind it.
  always_comb begin
    state_nxt = state;
    cmd_pop   = 1'b0;
    wdf_pop   = 1'b0;
    rd_issue  = 1'b0;
    wr_commit = 1'b0;
    bad_cmd   = 1'b0;
    case (state)
      S_CALIB: if (init_calib_complete) state_nxt = S_IDLE;
      S_IDLE: begin
        if (cmd_cnt != 3'd0) begin
          if (cmd_head.cmd == CMD_RD)      state_nxt = S_RD;
          else if (cmd_head.cmd == CMD_WR) state_nxt = S_WR;
          else begin
            cmd_pop = 1'b1;
            bad_cmd = 1'b1;
          end
        end
      end
      S_RD: begin
        rd_issue  = 1'b1;
        cmd_pop   = 1'b1;
        state_nxt = S_IDLE;
      end
      S_WR: begin
        if (wdf_cnt != 3'd0) begin
          wr_commit = 1'b1;
          cmd_pop   = 1'b1;
          wdf_pop   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_CALIB;
    endcase
  end

  // Storage is never reset so contents survive a UI reset.
  always_ff @(posedge ui_clk) begin
    if (wr_commit) begin
      for (int b = 0; b < int'(MASK_W); b++) begin
        if (!wdf_mask_q[wdf_rp][b])
          mem[cmd_head.idx][b*8 +: 8] <= wdf_data_q[wdf_rp][b*8 +: 8];
      end
    end
  end

  // Read return pipe; each data stage only loads behind a token so the output holds.
  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      vld_pipe <= '0;
      for (int i = 0; i < int'(RD_LATENCY); i++) dat_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= rd_issue;
      if (rd_issue) dat_pipe[0] <= mem[cmd_head.idx];
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign app_rd_data       = dat_pipe[RD_LATENCY-1];
  assign app_rd_data_valid = vld_pipe[RD_LATENCY-1];
  assign app_rd_data_end   = vld_pipe[RD_LATENCY-1];

endmodule

// File: tb/tb_mig_ui_responder.sv
// Directed bench for mig_ui_responder: one plain instance and one with LFSR backpressure.
module tb_mig_ui_responder;

  logic         clk;
  logic         rst;
  logic [27:0]  app_addr;
  logic [2:0]   app_cmd;
  logic [127:0] wdf_data;
  logic [15:0]  wdf_mask;

  logic a_en, a_rdy, a_wren, a_wdf_end, a_wdf_rdy, a_valid, a_end, a_init, a_perr;
  logic b_en, b_rdy, b_wren, b_wdf_end, b_wdf_rdy, b_valid, b_end, b_init, b_perr;
  logic [127:0] a_rd_data, b_rd_data;

  int checks = 0;
  int errors = 0;

  assign a_wdf_end = a_wren;
  assign b_wdf_end = b_wren;

  mig_ui_responder #(.ADDR_W(28), .DATA_W(128), .MEM_AW(10), .RD_LATENCY(4),
                     .CALIB_CYCLES(64), .BACKPRESSURE(0)) dut (
    .ui_clk(clk), .ui_clk_sync_rst(rst), .app_addr(app_addr), .app_cmd(app_cmd),
    .app_en(a_en), .app_rdy(a_rdy), .app_wdf_data(wdf_data), .app_wdf_mask(wdf_mask),
    .app_wdf_wren(a_wren), .app_wdf_end(a_wdf_end), .app_wdf_rdy(a_wdf_rdy),
    .app_rd_data(a_rd_data), .app_rd_data_valid(a_valid), .app_rd_data_end(a_end),
    .init_calib_complete(a_init), .proto_err(a_perr));

  mig_ui_responder #(.ADDR_W(28), .DATA_W(128), .MEM_AW(10), .RD_LATENCY(4),
                     .CALIB_CYCLES(64), .BACKPRESSURE(1)) dut_bp (
    .ui_clk(clk), .ui_clk_sync_rst(rst), .app_addr(app_addr), .app_cmd(app_cmd),
    .app_en(b_en), .app_rdy(b_rdy), .app_wdf_data(wdf_data), .app_wdf_mask(wdf_mask),
    .app_wdf_wren(b_wren), .app_wdf_end(b_wdf_end), .app_wdf_rdy(b_wdf_rdy),
    .app_rd_data(b_rd_data), .app_rd_data_valid(b_valid), .app_rd_data_end(b_end),
    .init_calib_complete(b_init), .proto_err(b_perr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input bit which, input logic [2:0] cmd, input logic [27:0] addr);
    int n = 0;
    app_cmd  = cmd;
    app_addr = addr;
    if (which) b_en = 1'b1; else a_en = 1'b1;
    while (!(which ? b_rdy : a_rdy) && n < 500) begin tick(); n++; end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL cmd_accept_timeout: app_rdy stayed 0, required 1");
    end
    tick();
    a_en = 1'b0;
    b_en = 1'b0;
  endtask

  task automatic send_data(input bit which, input logic [127:0] data, input logic [15:0] mask);
    int n = 0;
    wdf_data = data;
    wdf_mask = mask;
    if (which) b_wren = 1'b1; else a_wren = 1'b1;
    while (!(which ? b_wdf_rdy : a_wdf_rdy) && n < 500) begin tick(); n++; end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL wdf_accept_timeout: app_wdf_rdy stayed 0, required 1");
    end
    tick();
    a_wren = 1'b0;
    b_wren = 1'b0;
  endtask

  task automatic wait_rd(input bit which, output logic [127:0] data);
    int n = 0;
    do begin tick(); n++; end while (!(which ? b_valid : a_valid) && n < 200);
    data = which ? b_rd_data : a_rd_data;
    if (!(which ? b_valid : a_valid)) begin
      checks++; errors++;
      data = 'x;
      $display("FAIL rd_valid_timeout: app_rd_data_valid stayed 0, required 1");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({a_rdy, a_wdf_rdy, a_valid, a_end, a_init, a_perr} !== 6'b0 || a_rd_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: flags=%b data=%h, required all 0",
               {a_rdy, a_wdf_rdy, a_valid, a_end, a_init, a_perr}, a_rd_data);
    end
    rst = 1'b0;
    for (int cyc = 1; cyc <= 64; cyc++) begin
      if (cyc == 10) begin app_cmd = 3'b001; a_en = 1'b1; end
      tick();
      a_en = 1'b0;
      if (cyc == 10) begin
        checks++;
        if (a_perr !== 1'b1) begin errors++; $display("FAIL early_en_proto_err: got %b required 1", a_perr); end
      end
      if (cyc == 63) begin
        checks++;
        if ({a_init, a_rdy, a_wdf_rdy} !== 3'b000) begin
          errors++; $display("FAIL calib_cycle63: init/rdy/wdf_rdy=%b required 000", {a_init, a_rdy, a_wdf_rdy});
        end
      end
    end
    checks++;
    if ({a_init, a_rdy, a_wdf_rdy} !== 3'b111) begin
      errors++; $display("FAIL calib_cycle64: init/rdy/wdf_rdy=%b required 111", {a_init, a_rdy, a_wdf_rdy});
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({a_perr, a_init} !== 2'b00) begin
      errors++; $display("FAIL rereset_clears: perr/init=%b required 00", {a_perr, a_init});
    end
    rst = 1'b0;
    for (int cyc = 1; cyc <= 64; cyc++) tick();
    checks++;
    if ({a_init, b_init} !== 2'b11) begin
      errors++; $display("FAIL recalib: init a/b=%b required 11", {a_init, b_init});
    end
  endtask

  task automatic test_write_read();
    logic [127:0] d = 128'h0123456789ABCDEF0123456789ABCDEF;
    send_cmd(0, 3'b000, 28'h0000010);
    send_data(0, d, 16'h0000);
    repeat (5) tick();
    checks++;
    if (a_rdy !== 1'b1) begin errors++; $display("FAIL pre_read_rdy: got %b required 1", a_rdy); end
    app_cmd = 3'b001; app_addr = 28'h0000010; a_en = 1'b1;
    tick();
    a_en = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (a_valid !== (k == 5) || a_end !== (k == 5)) begin
        errors++;
        $display("FAIL rd_latency k=%0d: valid=%b end=%b required %b", k, a_valid, a_end, (k == 5));
      end
      if (k >= 5) begin
        checks++;
        if (a_rd_data !== d) begin errors++; $display("FAIL rd_data k=%0d: got %h required %h", k, a_rd_data, d); end
      end
    end
  endtask

  task automatic test_mask();
    logic [127:0] got;
    logic [127:0] exp = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
    send_cmd(0, 3'b000, 28'h0000010);
    send_data(0, {128{1'b1}}, 16'h0000);
    send_cmd(0, 3'b000, 28'h0000010);
    send_data(0, 128'h0, 16'h00FF);
    send_cmd(0, 3'b001, 28'h0000010);
    wait_rd(0, got);
    checks++;
    if (got !== exp) begin errors++; $display("FAIL byte_mask: got %h required %h", got, exp); end
  endtask

  task automatic test_hol_stall();
    logic [127:0] d4 = 128'h4444_0000_1111_2222_3333_4444_5555_6666;
    logic [127:0] d5 = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;
    logic [127:0] d6 = 128'h6666_1234_5678_9ABC_DEF0_0FED_CBA9_8765;
    logic [127:0] got;
    send_cmd(0, 3'b000, 28'h0000028);
    send_data(0, d5, 16'h0000);
    send_cmd(0, 3'b000, 28'h0000030);
    send_data(0, d6, 16'h0000);
    repeat (6) tick();
    send_cmd(0, 3'b000, 28'h0000020);
    send_cmd(0, 3'b001, 28'h0000028);
    send_cmd(0, 3'b001, 28'h0000030);
    checks++;
    if (a_rdy !== 1'b1) begin errors++; $display("FAIL rdy_three_queued: got %b required 1", a_rdy); end
    send_cmd(0, 3'b001, 28'h0000020);
    checks++;
    if (a_rdy !== 1'b0) begin errors++; $display("FAIL rdy_four_queued: got %b required 0", a_rdy); end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (a_valid !== 1'b0) begin errors++; $display("FAIL stall_no_read k=%0d: valid=%b required 0", k, a_valid); end
    end
    send_data(0, d4, 16'h0000);
    wait_rd(0, got);
    checks++;
    if (got !== d5) begin errors++; $display("FAIL order_line5: got %h required %h", got, d5); end
    wait_rd(0, got);
    checks++;
    if (got !== d6) begin errors++; $display("FAIL order_line6: got %h required %h", got, d6); end
    wait_rd(0, got);
    checks++;
    if (got !== d4) begin errors++; $display("FAIL raw_line4: got %h required %h", got, d4); end
  endtask

  task automatic test_alias();
    logic [127:0] d = 128'hDEAD_BEEF_CAFE_F00D_0BAD_F00D_1357_9BDF;
    logic [127:0] got;
    send_cmd(0, 3'b000, 28'h0002000);
    send_data(0, d, 16'h0000);
    send_cmd(0, 3'b001, 28'h0000000);
    wait_rd(0, got);
    checks++;
    if (got !== d) begin errors++; $display("FAIL alias_line0: got %h required %h", got, d); end
    send_cmd(0, 3'b001, 28'h0002000);
    wait_rd(0, got);
    checks++;
    if (got !== d) begin errors++; $display("FAIL alias_high: got %h required %h", got, d); end
  endtask

  task automatic test_illegal_cmd();
    logic [127:0] got;
    checks++;
    if (a_perr !== 1'b0) begin errors++; $display("FAIL perr_before_illegal: got %b required 0", a_perr); end
    send_cmd(0, 3'b010, 28'h0000000);
    repeat (3) tick();
    checks++;
    if (a_perr !== 1'b1) begin errors++; $display("FAIL perr_illegal: got %b required 1", a_perr); end
    send_cmd(0, 3'b001, 28'h0000010);
    wait_rd(0, got);
    checks++;
    if (got !== {64'h0, 64'hFFFF_FFFF_FFFF_FFFF}) begin
      errors++; $display("FAIL read_after_illegal: got %h required %h", got, {64'h0, 64'hFFFF_FFFF_FFFF_FFFF});
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] ref_mem [64];
    logic [127:0] data, got;
    logic [15:0]  mask;
    int           line;
    for (int i = 0; i < 200; i++) begin
      line = (i < 64) ? i : int'($urandom_range(0, 63));
      data = {$urandom, $urandom, $urandom, $urandom};
      mask = (i < 64) ? 16'h0000 : 16'($urandom);
      send_cmd(1, 3'b000, 28'(line * 8 + int'($urandom_range(0, 7))));
      send_data(1, data, mask);
      for (int b = 0; b < 16; b++)
        if (!mask[b]) ref_mem[line][b*8 +: 8] = data[b*8 +: 8];
    end
    for (int l = 0; l < 64; l++) begin
      send_cmd(1, 3'b001, 28'(l * 8));
      wait_rd(1, got);
      checks++;
      if (got !== ref_mem[l]) begin errors++; $display("FAIL bp_line%0d: got %h required %h", l, got, ref_mem[l]); end
    end
    checks++;
    if (b_perr !== 1'b0) begin errors++; $display("FAIL bp_proto_err: got %b required 0", b_perr); end
  endtask

  initial begin
    app_addr = '0; app_cmd = '0; wdf_data = '0; wdf_mask = '0;
    a_en = 1'b0; a_wren = 1'b0; b_en = 1'b0; b_wren = 1'b0;
    test_reset();
    test_write_read();
    test_mask();
    test_hol_stall();
    test_alias();
    test_illegal_cmd();
    test_backpressure();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mig_ui_responder.md
Name: mig_ui_responder

Overview:
- Synthesizable stand-in for the MIG 7-series user interface (UI), seen from the memory side.
- Answers app_cmd, app_en and app_wdf_* from the DDR3 read/write engine, and returns app_rd_data with the same handshake timing class as the real core.
- Storage is on-chip block RAM. No DDR3 device or calibration is involved.
- Used for board-less simulation and for FPGA bring-up of the FIFO, read/write and frame-buffer path before the PHY is closed.

Parameters:
- ADDR_W, 28: app_addr width, in 16-bit DDR word units.
- DATA_W, 128: UI data width, one BL8 beat in 4:1 mode.
- MEM_AW, 10: log2 of storage depth, in DATA_W-bit lines.
- RD_LATENCY, 4: cycles from memory read issue to app_rd_data_valid. Legal range 1..15.
- CALIB_CYCLES, 64: cycles after reset release before init_calib_complete asserts.
- BACKPRESSURE, 0: when 1, a 16-bit LFSR (seed 16'hACE1) deasserts app_rdy and app_wdf_rdy on pseudo-random cycles.

Ports:
- ui_clk  in  1  sole clock.
- ui_clk_sync_rst  in  1  asynchronous, active-high reset.
- app_addr  in  ADDR_W  command address.
- app_cmd  in  3  3'b000 = write, 3'b001 = read.
- app_en  in  1  command valid.
- app_rdy  out  1  command accepted when app_en && app_rdy.
- app_wdf_data  in  DATA_W  write data.
- app_wdf_mask  in  DATA_W/8  byte mask; 1 = byte not written.
- app_wdf_wren  in  1  write data valid.
- app_wdf_end  in  1  last beat; must equal app_wdf_wren.
- app_wdf_rdy  out  1  write data accepted when app_wdf_wren && app_wdf_rdy.
- app_rd_data  out  DATA_W  read data.
- app_rd_data_valid  out  1  read data valid.
- app_rd_data_end  out  1  equals app_rd_data_valid.
- init_calib_complete  out  1  UI usable.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (async, active-high): all outputs 0, both FIFOs empty, calibration counter 0, FSM in CALIB, LFSR reloaded with its seed.
- Reset asserted mid-operation aborts pending commands and data. Memory contents are not cleared.
- Calibration: the counter runs from reset release. init_calib_complete rises exactly CALIB_CYCLES cycles after release and stays high until the next reset.
- app_rdy = calib_done && !cmd_fifo_full && !lfsr_block.
  - lfsr_block = BACKPRESSURE && lfsr[0].
  - app_rdy is 0 throughout CALIB.
- app_wdf_rdy = calib_done && !wdf_fifo_full && !(BACKPRESSURE && lfsr[1]).
- Command FIFO: 4 entries of {cmd, line index}.
  - Line index = app_addr[3+MEM_AW-1:3].
  - app_addr[2:0] is ignored.
  - Address bits above the index are ignored, so out-of-range addresses wrap.
- Write-data FIFO: 4 entries of {data, mask}.
  - Data may arrive before, with, or after its command.
- Service FSM:
  - CALIB -> IDLE when calib_done.
  - IDLE with cmd FIFO non-empty: read -> RD, write -> WR.
  - RD: one cycle. Issues the memory read, pops the command, pushes a token into a RD_LATENCY-deep valid/data shift pipe. Returns to IDLE.
  - WR: waits while the wdf FIFO is empty (head-of-line stall; later reads wait too, so ordering is preserved). When data is present, writes unmasked bytes, pops the command and the data, returns to IDLE.
- Illegal app_cmd: accepted, dropped in IDLE, sets proto_err.
- Ordering:
  - All commands execute in acceptance order.
  - Read data returns in command order.
  - A read queued after a write to the same line returns the new data.
- Read latency: with both FIFOs empty and no stall, a read accepted on edge N gives app_rd_data_valid high in the cycle after edge N+1+RD_LATENCY. That cycle is exactly one pulse per read command.
- Read data and flag hold rules:
  - app_rd_data holds its last value when valid is low.
  - app_rd_data_end mirrors valid.
  - There is no back-pressure on read data.
- proto_err is set by any of the following, and clears only on reset:
  - app_wdf_wren && !app_wdf_end.
  - app_wdf_end && !app_wdf_wren.
  - app_en while !init_calib_complete.
  - Illegal cmd.
- Simultaneous events:
  - A command push and pop in the same cycle, and a data push and pop in the same cycle, are both legal.
  - A full FIFO with simultaneous pop still deasserts rdy that cycle, because rdy is computed from registered full flags.

Test Plan:
- Reset release, CALIB_CYCLES=64 -> init_calib_complete rises at cycle 64. app_rdy = 0 before then. app_en at cycle 10 sets proto_err.
- Write addr 28'h0000010, data 128'h0123..CDEF, mask 0; then read addr 28'h0000010 -> one app_rd_data_valid pulse RD_LATENCY+1 cycles after acceptance, data 128'h0123..CDEF, app_rd_data_end = 1 on that cycle.
- Write 128'hFFFF..FF to line 2, then write 128'h0 with mask 16'h00FF, then read -> upper 8 bytes 0, lower 8 bytes FF.
- Write command issued 6 cycles before its data, with reads to lines 5 and 6 queued behind it -> reads wait, both return after the write completes, in order 5 then 6. app_rdy falls once 4 commands are queued.
- Address 28'h0002000 with MEM_AW=10 -> aliases to line 0, i.e. the same data as address 28'h0000000.
- BACKPRESSURE=1, 200 random writes then reads over 64 lines -> all data matches a reference model, proto_err stays 0, app_wdf_end tied to app_wdf_wren.
